// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock packet FIFO controllers (write and read side).
package fifo_pkg;

   // Widest pointer the helpers are expected to handle.
   localparam int PTR_MAX_W = 32;

   // Binary to reflected Gray code; callers truncate to their pointer width.
   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Occupancy between two binary pointers of 'width' bits, modulo 2**width.
   // Pointers carry one extra MSB, so a result of 2**(width-1) means full.
   function automatic logic [PTR_MAX_W-1:0] fifo_level(input logic [PTR_MAX_W-1:0] wr,
                                                       input logic [PTR_MAX_W-1:0] rd,
                                                       input int unsigned         width);
      logic [PTR_MAX_W-1:0] mask;
      mask = (width >= PTR_MAX_W) ? '1 : ((PTR_MAX_W'(1) << width) - PTR_MAX_W'(1));
      return (wr - rd) & mask;
   endfunction

endpackage

// File: rtl/gray_code_decode.sv
// Purely combinational Gray to binary conversion: each binary bit is the XOR
// of all Gray bits at or above its position.
module gray_code_decode #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // One XOR-reduction per output bit, MSB passes straight through.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller for the dual-clock packet FIFOs. Lives entirely
// in the write clock domain: accepts writes, drives the RAM write port, publishes
// a registered Gray write pointer and derives full / almost_full / level from the
// already-synchronized Gray read pointer.
module async_fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH        = 4,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  ptr_err
);

   // Pointers carry one extra MSB to tell full from empty.
   localparam int            PW     = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH  = PW'(2 ** ADDR_WIDTH);
   localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LEVEL);

   logic [PW-1:0] wr_ptr_bin;
   logic [PW-1:0] wr_ptr_bin_next;
   logic [PW-1:0] wr_ptr_gray_next;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] level_next;
   logic          overflow;
   logic          full_next;
   logic          almost_full_next;
   logic          ptr_err_next;

   // Read pointer arrives already synchronized; decode only, no extra register
   // so the free-space view is not delayed beyond the synchronizer itself.
   gray_code_decode #(.WIDTH(PW)) u_rd_decode (
      .gray (rd_ptr_gray_sync),
      .bin  (rd_bin)
   );

   // Handshake: ready is simply not-full, so a full FIFO never overwrites.
   assign wr_ready    = ~full;
   assign ram_wr_en   = wr_valid & wr_ready;
   assign ram_wr_addr = wr_ptr_bin[ADDR_WIDTH-1:0];

   // Next pointer, its Gray image and the occupancy seen after this edge.
   always_comb begin
      wr_ptr_bin_next  = wr_ptr_bin + PW'(ram_wr_en);
      wr_ptr_gray_next = PW'(bin2gray(PTR_MAX_W'(wr_ptr_bin_next)));
      level_next       = PW'(fifo_level(PTR_MAX_W'(wr_ptr_bin_next),
                                        PTR_MAX_W'(rd_bin),
                                        unsigned'(PW)));
      // An occupancy beyond DEPTH can only come from a corrupt read pointer;
      // treat it as full so nothing more is written, and flag it.
      overflow         = (level_next > DEPTH);
      full_next        = (level_next == DEPTH) | overflow;
      almost_full_next = (level_next >= AF_LVL);
      ptr_err_next     = ptr_err | overflow;
   end

   // Pointer and flag registers; Gray pointer is always registered so the
   // read domain only ever sees a single-bit change per edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_bin  <= '0;
         wr_ptr_gray <= '0;
         level       <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         ptr_err     <= 1'b0;
      end else begin
         wr_ptr_bin  <= wr_ptr_bin_next;
         wr_ptr_gray <= wr_ptr_gray_next;
         level       <= level_next;
         full        <= full_next;
         almost_full <= almost_full_next;
         ptr_err     <= ptr_err_next;
      end
   end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl (ADDR_WIDTH=4, ALMOST_FULL_LEVEL=12).
// Stimulus pushes expected write addresses and per-cycle status snapshots into
// queues; a negedge monitor pops and compares them against the DUT.
module tb_async_fifo_wr_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic       wr_ready;
   logic       ram_wr_en;
   logic [3:0] ram_wr_addr;
   logic [4:0] wr_ptr_gray;
   logic [4:0] rd_ptr_gray_sync;
   logic       full;
   logic       almost_full;
   logic [4:0] level;
   logic       ptr_err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      string      nm;
      logic [4:0] lvl;
      logic       f;
      logic       af;
      logic       rdy;
      logic       err;
      logic [4:0] gr;
   } exp_t;

   exp_t       st_q[$];
   logic [3:0] addr_q[$];

   async_fifo_wr_ctrl #(.ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12)) dut (
      .clock            (clock),
      .reset            (reset),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .ram_wr_en        (ram_wr_en),
      .ram_wr_addr      (ram_wr_addr),
      .wr_ptr_gray      (wr_ptr_gray),
      .rd_ptr_gray_sync (rd_ptr_gray_sync),
      .full             (full),
      .almost_full      (almost_full),
      .level            (level),
      .ptr_err          (ptr_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [4:0] g(input int x);
      logic [4:0] b;
      b = 5'(x);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_st(input string nm, input int lvl, input bit f, input bit af,
                            input bit err, input logic [4:0] gr);
      exp_t e;
      e.cyc = cyc; e.nm = nm; e.lvl = 5'(lvl); e.f = f; e.af = af;
      e.rdy = ~f; e.err = err; e.gr = gr;
      st_q.push_back(e);
   endtask

   // Monitor: compares every accepted write and every due status snapshot.
   always @(negedge clock) begin
      if (ram_wr_en === 1'b1) begin
         tests++;
         if (addr_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write cyc=%0d addr=%0d required no write", cyc, ram_wr_addr);
         end else begin
            logic [3:0] ea;
            ea = addr_q.pop_front();
            if (ram_wr_addr !== ea) begin
               fails++;
               $display("FAIL wr_addr cyc=%0d got=%0d exp=%0d", cyc, ram_wr_addr, ea);
            end
         end
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
         exp_t e;
         logic [13:0] got, want;
         e = st_q.pop_front();
         got  = {level, full, almost_full, wr_ready, ptr_err, wr_ptr_gray};
         want = {e.lvl, e.f, e.af, e.rdy, e.err, e.gr};
         tests++;
         if (e.cyc != cyc || got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got lvl=%0d full=%b af=%b rdy=%b err=%b gray=%b exp lvl=%0d full=%b af=%b rdy=%b err=%b gray=%b",
                     e.nm, cyc, level, full, almost_full, wr_ready, ptr_err, wr_ptr_gray,
                     e.lvl, e.f, e.af, e.rdy, e.err, e.gr);
         end
      end
   end

   initial begin
      reset = 1'b1; wr_valid = 1'b0; rd_ptr_gray_sync = 5'b0;
      step();
      expect_st("in_reset", 0, 0, 0, 0, 5'b00000);
      step();
      reset = 1'b0;
      expect_st("after_release", 0, 0, 0, 0, 5'b00000);

      // Fill 16 with read pointer parked at 0; almost_full from level 12.
      for (int k = 0; k < 16; k++) begin
         step();
         wr_valid = 1'b1;
         addr_q.push_back(4'(k));
         expect_st("fill", k, 0, (k >= 12), 0, g(k));
      end
      // Full: further requests stall, pointer holds.
      for (int k = 0; k < 6; k++) begin
         step();
         expect_st("full_hold", 16, 1, 1, 0, 5'b11000);
      end

      // Read pointer advances to 1: space appears one cycle later.
      step();
      rd_ptr_gray_sync = 5'b00001;
      expect_st("rd_step_same_cyc", 16, 1, 1, 0, 5'b11000);
      step();
      addr_q.push_back(4'd0);
      expect_st("rd_step_free", 15, 0, 1, 0, 5'b11000);
      step();
      wr_valid = 1'b0;
      expect_st("refull", 16, 1, 1, 0, 5'b11001);

      // Reset while full.
      step();
      reset = 1'b1;
      expect_st("rst_full", 0, 0, 0, 0, 5'b00000);
      step();
      reset = 1'b0;
      rd_ptr_gray_sync = 5'b0;
      expect_st("rst_full_rel", 0, 0, 0, 0, 5'b00000);

      // Stream 40 writes, read pointer trailing by 3; wraps 31 -> 0.
      for (int i = 0; i < 40; i++) begin
         step();
         wr_valid = 1'b1;
         rd_ptr_gray_sync = (i >= 3) ? g(i - 3) : 5'b0;
         addr_q.push_back(4'(i % 16));
         expect_st("stream", (i < 4) ? i : 4, 0, 0, 0, g(i % 32));
      end
      step();
      wr_valid = 1'b0;
      rd_ptr_gray_sync = g(33);
      expect_st("stream_end", 4, 0, 0, 0, g(8));
      step();
      expect_st("level7", 7, 0, 0, 0, g(8));

      // Reset mid-operation with level 7: clears the same cycle.
      step();
      reset = 1'b1;
      expect_st("rst_mid", 0, 0, 0, 0, 5'b00000);
      step();
      reset = 1'b0;
      rd_ptr_gray_sync = 5'b0;
      expect_st("rst_mid_rel", 0, 0, 0, 0, 5'b00000);

      // Read pointer 16 with write pointer 0 -> full; read pointer 15 -> level 17, error.
      step();
      rd_ptr_gray_sync = 5'b11000;
      expect_st("rd16_pre", 0, 0, 0, 0, 5'b00000);
      step();
      rd_ptr_gray_sync = g(15);
      expect_st("rd16_full", 16, 1, 1, 0, 5'b00000);
      step();
      rd_ptr_gray_sync = 5'b0;
      expect_st("overflow_err", 17, 1, 1, 1, 5'b00000);
      step();
      expect_st("err_sticky", 0, 0, 0, 1, 5'b00000);
      step();
      reset = 1'b1;
      expect_st("err_cleared", 0, 0, 0, 0, 5'b00000);
      step();
      reset = 1'b0;
      step();
      step();

      tests++;
      if (addr_q.size() != 0 || st_q.size() != 0) begin
         fails++;
         $display("FAIL drain addr_left=%0d status_left=%0d required 0 0", addr_q.size(), st_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
